// File: rtl/dmem_responder_if.sv
// Load/store port between the pipeline memory stage and the data-memory responder.
// Latency: n/a (signal bundle only).
// Backpressure: the pipeline holds its request while mem_busy is high.
//
// Signals:
//   MemReadM/MemWriteM  load / store request strobes (store wins if both are set)
//   Mem_WrAddr          byte address for loads and stores
//   Mem_WrData          store data, right-justified for sb/sh
//   funct3              RV32I access size / sign encoding
//   ReadData            registered, extended load result
//   mem_busy            stall back to the pipeline
//   mem_valid/mem_err   one-cycle response and error strobes
interface dmem_responder_if;
  logic        MemReadM;
  logic        MemWriteM;
  logic [31:0] Mem_WrAddr;
  logic [31:0] Mem_WrData;
  logic [2:0]  funct3;
  logic [31:0] ReadData;
  logic        mem_busy;
  logic        mem_valid;
  logic        mem_err;

  // Pipeline side.
  modport master (
    output MemReadM, MemWriteM, Mem_WrAddr, Mem_WrData, funct3,
    input  ReadData, mem_busy, mem_valid, mem_err
  );

  // Responder side.
  modport slave (
    input  MemReadM, MemWriteM, Mem_WrAddr, Mem_WrData, funct3,
    output ReadData, mem_busy, mem_valid, mem_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM with RV32I byte/half/word stores and sign/zero-extended loads.
// Latency: WAIT_CYCLES+1 cycles from acceptance to the mem_valid/mem_err strobe.
// Backpressure: mem_busy stalls the pipeline; requests seen while in WAIT are ignored.
//
// Ports: clk, reset (synchronous, active-high), bus (dmem_responder_if.slave).
// Parameters: DEPTH_WORDS (power of two, >= 4), WAIT_CYCLES (0..15).
// Optional macro DMEM_MISALIGN_TRAP_EN: misaligned half/word accesses report mem_err
// instead of being force-aligned.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state;
  logic [3:0]      wait_cnt;
  logic [AW+1:0]   lat_addr;
  logic [31:0]     lat_data;
  logic [2:0]      lat_f3;
  logic            lat_store;

  logic            req;
  logic            accept;
  logic            commit;

  // Operands of the access being committed this cycle.
  logic [AW+1:0]   c_addr;
  logic [31:0]     c_data;
  logic [2:0]      c_f3;
  logic            c_store;

  logic [1:0]      a_lo;
  logic [AW-1:0]   idx;
  logic            bad;
  logic            is_half;
  logic            is_word;
  logic [3:0]      be;
  logic [31:0]     wdat;
  logic [31:0]     rword;
  logic [7:0]      rbyte;
  logic [15:0]     rhalf;
  logic [31:0]     ld_val;

  logic [31:0]     mem [DEPTH_WORDS];

  // Address bits above the RAM size are deliberately ignored (addresses wrap).
  logic            unused_addr_bits;
  assign unused_addr_bits = ^bus.Mem_WrAddr[31:AW+2];

  assign req    = bus.MemReadM | bus.MemWriteM;
  assign accept = req && (state != WAIT);

  // Without wait states the access commits on its own acceptance edge, so the
  // live request is used; otherwise the latched copy is committed from WAIT.
  assign commit = (WAIT_CYCLES == 0) ? accept : ((state == WAIT) && (wait_cnt == 4'd0));

  assign bus.mem_busy = (state == WAIT) || (req && (WAIT_CYCLES > 0));

  always_comb begin
    c_addr  = lat_addr;
    c_data  = lat_data;
    c_f3    = lat_f3;
    c_store = lat_store;
    if (WAIT_CYCLES == 0) begin
      c_addr  = bus.Mem_WrAddr[AW+1:0];
      c_data  = bus.Mem_WrData;
      c_f3    = bus.funct3;
      c_store = bus.MemWriteM;
    end
  end

  always_comb begin
    a_lo    = c_addr[1:0];
    idx     = c_addr[AW+1:2];
    is_half = (c_f3[1:0] == 2'b01);
    is_word = (c_f3[1:0] == 2'b10);

    // Stores: only 000/001/010 are legal. Loads: 011, 110, 111 are illegal.
    if (c_store) bad = c_f3[2] | (c_f3[1:0] == 2'b11);
    else         bad = (c_f3[1:0] == 2'b11) | (c_f3[2] & c_f3[1]);

`ifdef DMEM_MISALIGN_TRAP_EN
    if ((is_half && a_lo[0]) || (is_word && (a_lo != 2'b00))) bad = 1'b1;
`else
    if (is_half) a_lo[0] = 1'b0;
    if (is_word) a_lo    = 2'b00;
`endif

    case (c_f3[1:0])
      2'b00: begin
        be   = 4'b0001 << a_lo;
        wdat = {4{c_data[7:0]}};
      end
      2'b01: begin
        be   = a_lo[1] ? 4'b1100 : 4'b0011;
        wdat = {2{c_data[15:0]}};
      end
      default: begin
        be   = 4'b1111;
        wdat = c_data;
      end
    endcase
    if (bad || !c_store) be = 4'b0000;

    rword = mem[idx];
    rbyte = 8'(rword >> {a_lo, 3'b000});
    rhalf = a_lo[1] ? rword[31:16] : rword[15:0];

    // funct3[2] selects zero extension (lbu/lhu).
    case (c_f3[1:0])
      2'b00:   ld_val = {{24{~c_f3[2] & rbyte[7]}}, rbyte};
      2'b01:   ld_val = {{16{~c_f3[2] & rhalf[15]}}, rhalf};
      default: ld_val = rword;
    endcase
    if (bad) ld_val = 32'd0;
  end

  // RAM write port; a reset on the commit edge drops the write.
  always_ff @(posedge clk) begin
    if (!reset && commit) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdat[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      wait_cnt      <= 4'd0;
      lat_addr      <= '0;
      lat_data      <= 32'd0;
      lat_f3        <= 3'd0;
      lat_store     <= 1'b0;
      bus.mem_valid <= 1'b0;
      bus.mem_err   <= 1'b0;
      bus.ReadData  <= 32'd0;
    end else begin
      bus.mem_valid <= 1'b0;
      bus.mem_err   <= 1'b0;

      if (commit) begin
        bus.mem_valid <= 1'b1;
        bus.mem_err   <= bad;
        if (!c_store) bus.ReadData <= ld_val;
      end

      case (state)
        IDLE, RESP: begin
          if (accept) begin
            lat_addr  <= bus.Mem_WrAddr[AW+1:0];
            lat_data  <= bus.Mem_WrData;
            lat_f3    <= bus.funct3;
            lat_store <= bus.MemWriteM;
            if (WAIT_CYCLES > 0) begin
              state    <= WAIT;
              wait_cnt <= CNT_INIT;
            end else begin
              state <= RESP;
            end
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (wait_cnt == 4'd0) state <= RESP;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
